// File: rtl/alu_sequencer.sv
// alu_sequencer: one-at-a-time ALU front end with iterative MUL/DIV/MOD and valid/ready request/response channels
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_d0,
  input  logic [WIDTH-1:0] req_d1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ITER, FIX, RESP} st_t;
  st_t st, st_n;
  logic [3:0] op_q, op_n;
  logic [WIDTH-1:0] a, a_n, b, b_n, acc, acc_n, data, data_n, alu;
  logic [CW-1:0] cnt, cnt_n;
  logic err, err_n, nq, nq_n, nr, nr_n;
  logic [WIDTH:0] shifted, diff;
  logic single, mdiv;
  assign req_ready = st == IDLE;
  assign rsp_valid = st == RESP;
  assign busy      = st != IDLE;
  assign rsp_data  = data;
  assign rsp_err   = err;
  always_comb begin
    case (req_op)
      4'h0: alu = req_d0 | req_d1;
      4'h1: alu = req_d0 ^ req_d1;
      4'h2: alu = req_d0 & req_d1;
      4'h4: alu = req_d0 + req_d1;
      4'h5: alu = req_d0 - req_d1;
      4'h8: alu = req_d0 << req_d1;
      4'h9: alu = $signed(req_d0) >>> req_d1;
      default: alu = '0;
    endcase
  end
  always_comb begin
    st_n = st; op_n = op_q; a_n = a; b_n = b; acc_n = acc; cnt_n = cnt;
    data_n = data; err_n = err; nq_n = nq; nr_n = nr;
    single = req_op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9};
    mdiv = req_op inside {4'hA, 4'hB};
    // restoring step: acc holds the partial remainder, a shifts dividend out and quotient in
    shifted = {acc, a[WIDTH-1]};
    diff = shifted - {1'b0, b};
    case (st)
      IDLE: if (req_valid) begin
        op_n = req_op;
        cnt_n = '0;
        acc_n = '0;
        if (single) begin
          data_n = alu; err_n = 1'b0; st_n = RESP;
        end else if (mdiv && req_d1 == '0) begin
          data_n = req_op == 4'hB ? req_d0 : '1; err_n = 1'b1; st_n = RESP;
        end else if (mdiv) begin
          a_n = req_d0[WIDTH-1] ? -req_d0 : req_d0;
          b_n = req_d1[WIDTH-1] ? -req_d1 : req_d1;
          nq_n = req_d0[WIDTH-1] ^ req_d1[WIDTH-1];
          nr_n = req_d0[WIDTH-1];
          st_n = ITER;
        end else if (req_op == 4'h6) begin
          a_n = req_d0; b_n = req_d1; st_n = ITER;
        end else begin
          data_n = '0; err_n = 1'b1; st_n = RESP;
        end
      end
      ITER: begin
        cnt_n = cnt + 1'b1;
        if (op_q == 4'h6) begin
          acc_n = acc + (b[0] ? a : '0);
          a_n = a << 1;
          b_n = b >> 1;
        end else begin
          acc_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          a_n = {a[WIDTH-2:0], ~diff[WIDTH]};
        end
        if (cnt == CW'(WIDTH-1)) begin
          st_n = op_q == 4'h6 ? RESP : FIX;
          data_n = acc_n;
          err_n = 1'b0;
        end
      end
      FIX: begin
        data_n = op_q == 4'hB ? (nr ? -acc : acc) : (nq ? -a : a);
        err_n = 1'b0;
        st_n = RESP;
      end
      RESP: st_n = rsp_ready ? IDLE : RESP;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE; op_q <= '0; a <= '0; b <= '0; acc <= '0; cnt <= '0;
      data <= '0; err <= 1'b0; nq <= 1'b0; nr <= 1'b0;
    end else begin
      st <= st_n; op_q <= op_n; a <= a_n; b <= b_n; acc <= acc_n; cnt <= cnt_n;
      data <= data_n; err <= err_n; nq <= nq_n; nr <= nr_n;
    end
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle operation controller in front of the 32-bit integer ALU. It accepts one operation at a time over a valid/ready request channel. Single-cycle ops (OR/XOR/AND/ADD/SUB/SHL/SAR) are evaluated combinationally. MUL, DIV and MOD are sequenced iteratively. One result per operation is returned over a valid/ready response channel. It sits between the instruction decode/issue stage and the register-file writeback.

Parameters:
WIDTH, 32, operand/result width; iteration count for MUL/DIV/MOD equals WIDTH.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request this cycle
req_op  input  4  opcode: 0 OR, 1 XOR, 2 AND, 4 ADD, 5 SUB, 6 MUL, 8 SHL, 9 SAR, A DIV, B MOD
req_d0  input  WIDTH  left operand
req_d1  input  WIDTH  right operand
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_data  output  WIDTH  result (d0 op d1)
rsp_err  output  1  error flag qualifying rsp_data (illegal op or divide by zero)
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, iteration counter=0.
- Reset mid-operation aborts silently. No response is produced for the aborted request.
- States: IDLE, ITER, FIX, RESP.
- IDLE: req_ready=1. Request accepted on a cycle with req_valid & req_ready. Operands and op are latched.
  - Ops 0,1,2,4,5,8,9: result computed from the request inputs and registered. Next state is RESP, so rsp_valid rises 1 cycle after acceptance.
  - Ops 3,7,C,D,E,F: rsp_data=0, rsp_err=1. Next state is RESP, latency 1.
  - DIV/MOD with d1=0: DIV returns all-ones, MOD returns d0, rsp_err=1. Next state is RESP, latency 1.
  - MUL, or DIV/MOD with d1≠0: next state is ITER with counter=0.
- ITER: req_ready=0. Exactly WIDTH cycles, one iteration per cycle.
  - MUL: shift-add, keeping the low WIDTH bits. Signed and unsigned results are identical.
  - DIV/MOD: signed, truncating toward zero. Magnitudes are taken at acceptance, followed by restoring division, one quotient bit per cycle.
  - On counter=WIDTH-1: MUL goes to RESP; DIV/MOD go to FIX.
- FIX: one cycle of sign correction. Quotient is negated if operand signs differ. Remainder takes the sign of d0. Next state is RESP.
- Latency from acceptance to rsp_valid: single-cycle ops 1, MUL WIDTH+1 (33), DIV/MOD WIDTH+2 (34).
- RESP: rsp_valid=1, and rsp_data/rsp_err are held stable until rsp_ready. On rsp_valid & rsp_ready, the next state is IDLE and rsp_valid drops the next cycle. req_ready=0 in RESP, so there is no overlap. Maximum throughput is one single-cycle op per 2 clocks.
- rsp_err=0 for every legal, non-zero-divisor op.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH with no flags.
  - SHL/SAR use the full d1 value. Amounts ≥ WIDTH give 0 for SHL and a sign-fill of d0 for SAR.
  - Overflow case DIV -2^31 / -1 returns 0x80000000 and MOD returns 0, with rsp_err=0.
- req_d0/req_d1/req_op are don't-care outside the acceptance cycle. Changes during ITER/FIX/RESP must not affect the result.
- busy = (state≠IDLE).

Test Plan:
1. ADD 3+7: request op=4, d0=3, d1=7, rsp_ready=1 → rsp_valid exactly 1 cycle after acceptance, rsp_data=10, rsp_err=0, req_ready high again 2 cycles after acceptance.
2. MUL and backpressure: op=6, d0=0xFFFFFFFD (-3), d1=7 → rsp_valid at acceptance+33, rsp_data=0xFFFFFFEB (-21). Hold rsp_ready=0 for 5 cycles → rsp_data stable and req_ready=0 throughout.
3. Signed DIV/MOD: op=A, d0=-7, d1=2 → 0xFFFFFFFD (-3) at acceptance+34. op=B, same operands → 0xFFFFFFFF (-1). op=A, d0=0x80000000, d1=0xFFFFFFFF → 0x80000000, rsp_err=0.
4. Errors: op=A, d0=5, d1=0 → 0xFFFFFFFF, rsp_err=1, latency 1. op=B, d0=5, d1=0 → 5, rsp_err=1. op=7 → rsp_data=0, rsp_err=1.
5. Shifts: op=8, d0=1, d1=40 → 0. op=9, d0=0x80000000, d1=4 → 0xF8000000. op=9, d0=0x80000000, d1=33 → 0xFFFFFFFF.
6. Reset mid-op: start DIV, drop rst_n at iteration 10 → outputs return to reset values immediately, asynchronously. Release rst_n, then issue ADD 1+1 → rsp_data=2 at latency 1, and no stale DIV response appears.
